// File: rtl/vga_scan.sv
// -----------------------------------------------------------------------------
// vga_scan -- VGA raster generator with a 320x240 frame-buffer read port.
//
// Scans an 800x525 raster (640x480 visible at the default parameters),
// reads a 2x-doubled 320x240 frame buffer and drives a 6-bit DAC plus
// active-low sync. Every video output is delayed by two clocks from the
// counter state it describes, which absorbs the one-clock frame-buffer read
// latency.
//
// Ports
//   i_clk          pixel clock, all state updates on the rising edge
//   i_rst          synchronous active-high reset
//   i_rd_data      frame-buffer pixel {R[1:0],G[1:0],B[1:0]}, one clock late
//   o_rd_x/o_rd_y  frame-buffer read address (0 outside the active region)
//   o_red/green/blue  pixel colour, forced to 0 while blanking
//   o_hsync/o_vsync   active-low syncs
//   o_vblank       high while the raster is below the visible lines
//   o_frame_start  one-cycle pulse marking pixel (0,0) at the outputs
// -----------------------------------------------------------------------------
module vga_scan #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [5:0] i_rd_data,
   output logic [8:0] o_rd_x,
   output logic [7:0] o_rd_y,
   output logic [1:0] o_red,
   output logic [1:0] o_green,
   output logic [1:0] o_blue,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_vblank,
   output logic       o_frame_start
);

   // Counter bounds folded to the 10-bit counter width.
   localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

   // Timing flags after one register stage (aligned with i_rd_data).
   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic vblank;
      logic frame_start;
   } stage1_t;

   // Everything that leaves the block, registered once more.
   typedef struct packed {
      logic [5:0] rgb;
      logic       hsync;
      logic       vsync;
      logic       vblank;
      logic       frame_start;
   } stage2_t;

   // Idle values: syncs deasserted (high), everything else low.
   localparam stage1_t S1_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                   vblank: 1'b0, frame_start: 1'b0};
   localparam stage2_t S2_IDLE = '{rgb: 6'd0, hsync: 1'b1, vsync: 1'b1,
                                   vblank: 1'b0, frame_start: 1'b0};

   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       active;
   stage1_t    s1_q, s1_d;
   stage2_t    s2_q, s2_d;

   // ---------------------------------------------------------------------------
   // Raster counters. The line and frame wrap happen in the same cycle, so
   // (H_LAST, V_LAST) goes straight to (0,0).
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
   end

   assign active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);

   // Read address straight from the counters: 2x pixel doubling, parked at 0
   // while blanking so the frame buffer sees a quiet bus.
   assign o_rd_x = active ? h_cnt_q[9:1] : '0;
   assign o_rd_y = active ? v_cnt_q[8:1] : '0;

   // ---------------------------------------------------------------------------
   // Stage 1: decode timing flags from the counters.
   // ---------------------------------------------------------------------------
   always_comb begin
      s1_d.active      = active;
      s1_d.hsync       = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
      s1_d.vsync       = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
      s1_d.vblank      = (v_cnt_q >= V_ACT_END);
      s1_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
   end

   // ---------------------------------------------------------------------------
   // Stage 2: pixel data arrives now, one clock after its address; blank it
   // unless the matching stage-1 active flag is set.
   // ---------------------------------------------------------------------------
   always_comb begin
      s2_d.rgb         = s1_q.active ? i_rd_data : 6'd0;
      s2_d.hsync       = s1_q.hsync;
      s2_d.vsync       = s1_q.vsync;
      s2_d.vblank      = s1_q.vblank;
      s2_d.frame_start = s1_q.frame_start;
   end

   // Reset clears both stages as well as the counters, so a sync pulse in
   // flight is dropped at the reset edge rather than finished.
   always_ff @(posedge i_clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (i_rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         s1_q    <= S1_IDLE;
         s2_q    <= S2_IDLE;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
      end
   end

   assign o_red         = s2_q.rgb[5:4];
   assign o_green       = s2_q.rgb[3:2];
   assign o_blue        = s2_q.rgb[1:0];
   assign o_hsync       = s2_q.hsync;
   assign o_vsync       = s2_q.vsync;
   assign o_vblank      = s2_q.vblank;
   assign o_frame_start = s2_q.frame_start;

endmodule
